// File: rtl/usb_fs_attach_ctrl_if.sv
// UTMI-side signal bundle between usb_fs_attach_ctrl and the ULPI link wrapper.
// master: the attach controller (drives mode/termination/pulldown controls,
//         observes linestate and bus activity).
// slave:  the wrapper / device core side.
// Signals:
//   utmi_linestate_i   linestate (00 SE0, 01 J, 10 K, 11 SE1)
//   utmi_rxactive_i    receive activity from the wrapper
//   utmi_txvalid_i     transmit activity from the device core
//   utmi_op_mode_o     op_mode to wrapper (01 non-driving, 00 normal)
//   utmi_xcvrselect_o  transceiver select, constant 01 (FS)
//   utmi_termselect_o  1 = FS termination / D+ pull-up on
//   utmi_dppulldown_o  D+ pulldown, constant 0
//   utmi_dmpulldown_o  D- pulldown, constant 0
interface usb_fs_attach_ctrl_if;
    logic [1:0] utmi_linestate_i;
    logic       utmi_rxactive_i;
    logic       utmi_txvalid_i;
    logic [1:0] utmi_op_mode_o;
    logic [1:0] utmi_xcvrselect_o;
    logic       utmi_termselect_o;
    logic       utmi_dppulldown_o;
    logic       utmi_dmpulldown_o;

    modport master (
        input  utmi_linestate_i,
        input  utmi_rxactive_i,
        input  utmi_txvalid_i,
        output utmi_op_mode_o,
        output utmi_xcvrselect_o,
        output utmi_termselect_o,
        output utmi_dppulldown_o,
        output utmi_dmpulldown_o
    );

    modport slave (
        output utmi_linestate_i,
        output utmi_rxactive_i,
        output utmi_txvalid_i,
        input  utmi_op_mode_o,
        input  utmi_xcvrselect_o,
        input  utmi_termselect_o,
        input  utmi_dppulldown_o,
        input  utmi_dmpulldown_o
    );
endinterface

// File: rtl/usb_fs_attach_ctrl.sv
// Full-speed device attach and bus-state controller (60 MHz ULPI clock domain).
// Sequences the PHY from detached to attached, then detects bus reset (SE0),
// suspend (idle J) and resume (K) and reports them as registered status.
// Ports:
//   ulpi_clk60_i  60 MHz clock from PHY
//   ulpi_rst_i    asynchronous active-high reset
//   enable_i      software attach request; 0 forces detach
//   utmi          UTMI control/status bundle (master side)
//   attached_o    high in ATTACHED, BUS_RESET and SUSPENDED
//   bus_reset_o   high while in BUS_RESET
//   suspend_o     high while in SUSPENDED
//   resume_o      one-cycle pulse on the first ATTACHED cycle after K in suspend
//   state_o       current state encoding (debug)
module usb_fs_attach_ctrl #(
    parameter int unsigned ATTACH_DELAY   = 60000,
    parameter int unsigned RESET_DETECT   = 150,
    parameter int unsigned SUSPEND_DETECT = 180000
) (
    input  logic                        ulpi_clk60_i,
    input  logic                        ulpi_rst_i,
    input  logic                        enable_i,
    usb_fs_attach_ctrl_if.master        utmi,
    output logic                        attached_o,
    output logic                        bus_reset_o,
    output logic                        suspend_o,
    output logic                        resume_o,
    output logic [2:0]                  state_o
);

    typedef enum logic [2:0] {
        StDetached   = 3'd0,
        StWaitAttach = 3'd1,
        StAttached   = 3'd2,
        StBusReset   = 3'd3,
        StSuspended  = 3'd4
    } state_e;

    localparam logic [19:0] AttachLast  = 20'(ATTACH_DELAY - 1);
    localparam logic [19:0] ResetLast   = 20'(RESET_DETECT - 1);
    localparam logic [19:0] SuspendLast = 20'(SUSPEND_DETECT - 1);

    state_e      state_q, state_d;
    logic [19:0] wait_cnt_q, wait_cnt_d;
    logic [19:0] se0_cnt_q, se0_cnt_d;
    logic [19:0] idle_cnt_q, idle_cnt_d;
    logic        resume_q, resume_d;
    logic [1:0]  op_mode_q, op_mode_d;
    logic        termselect_q, termselect_d;
    logic [1:0]  xcvrselect_q;
    logic        dppulldown_q;
    logic        dmpulldown_q;

    logic ls_se0;
    logic ls_k;
    logic idle_j;

    assign ls_se0 = (utmi.utmi_linestate_i == 2'b00);
    assign ls_k   = (utmi.utmi_linestate_i == 2'b10);
    assign idle_j = (utmi.utmi_linestate_i == 2'b01) && !utmi.utmi_rxactive_i &&
                    !utmi.utmi_txvalid_i;

    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    // Counters default to zero, so any state change (where no increment is
    // assigned) leaves them cleared.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        se0_cnt_d  = '0;
        idle_cnt_d = '0;
        resume_d   = 1'b0;

        if (!enable_i) begin
            state_d = StDetached;
        end else begin
            case (state_q)
                StDetached: begin
                    state_d = StWaitAttach;
                end
                StWaitAttach: begin
                    if (wait_cnt_q == AttachLast) begin
                        state_d = StAttached;
                    end else begin
                        wait_cnt_d = sat_inc(wait_cnt_q);
                    end
                end
                StAttached: begin
                    // SE0 and idle J are mutually exclusive linestates.
                    if (ls_se0) begin
                        if (se0_cnt_q == ResetLast) begin
                            state_d = StBusReset;
                        end else begin
                            se0_cnt_d = sat_inc(se0_cnt_q);
                        end
                    end else if (idle_j) begin
                        if (idle_cnt_q == SuspendLast) begin
                            state_d = StSuspended;
                        end else begin
                            idle_cnt_d = sat_inc(idle_cnt_q);
                        end
                    end
                end
                StBusReset: begin
                    if (!ls_se0) begin
                        state_d = StAttached;
                    end
                end
                StSuspended: begin
                    if (ls_k) begin
                        state_d  = StAttached;
                        resume_d = 1'b1;
                    end else if (ls_se0) begin
                        if (se0_cnt_q == ResetLast) begin
                            state_d = StBusReset;
                        end else begin
                            se0_cnt_d = sat_inc(se0_cnt_q);
                        end
                    end
                end
                default: begin
                    state_d = StDetached;
                end
            endcase
        end
    end

    // PHY controls follow the next state so they are registered yet aligned
    // with the state register.
    always_comb begin
        op_mode_d    = 2'b01;
        termselect_d = 1'b0;
        if (state_d != StDetached && state_d != StWaitAttach) begin
            op_mode_d    = 2'b00;
            termselect_d = 1'b1;
        end
    end

    always_ff @(posedge ulpi_clk60_i or posedge ulpi_rst_i) begin
        if (ulpi_rst_i) begin
            state_q      <= StDetached;
            wait_cnt_q   <= '0;
            se0_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            resume_q     <= 1'b0;
            op_mode_q    <= 2'b01;
            termselect_q <= 1'b0;
            xcvrselect_q <= 2'b01;
            dppulldown_q <= 1'b0;
            dmpulldown_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            resume_q     <= resume_d;
            op_mode_q    <= op_mode_d;
            termselect_q <= termselect_d;
            xcvrselect_q <= 2'b01;
            dppulldown_q <= 1'b0;
            dmpulldown_q <= 1'b0;
        end
    end

    assign utmi.utmi_op_mode_o    = op_mode_q;
    assign utmi.utmi_xcvrselect_o = xcvrselect_q;
    assign utmi.utmi_termselect_o = termselect_q;
    assign utmi.utmi_dppulldown_o = dppulldown_q;
    assign utmi.utmi_dmpulldown_o = dmpulldown_q;

    assign state_o     = state_q;
    assign attached_o  = (state_q == StAttached) || (state_q == StBusReset) ||
                         (state_q == StSuspended);
    assign bus_reset_o = (state_q == StBusReset);
    assign suspend_o   = (state_q == StSuspended);
    assign resume_o    = resume_q;

endmodule

// File: tb/tb_usb_fs_attach_ctrl.sv
// Directed self-checking bench for usb_fs_attach_ctrl with short thresholds
// (ATTACH_DELAY=10, RESET_DETECT=5, SUSPEND_DETECT=20).
module tb_usb_fs_attach_ctrl;

    logic       ulpi_clk60_i = 1'b0;
    logic       ulpi_rst_i;
    logic       enable_i;
    logic       attached_o;
    logic       bus_reset_o;
    logic       suspend_o;
    logic       resume_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    usb_fs_attach_ctrl_if utmi ();

    usb_fs_attach_ctrl #(
        .ATTACH_DELAY   (10),
        .RESET_DETECT   (5),
        .SUSPEND_DETECT (20)
    ) dut (
        .ulpi_clk60_i (ulpi_clk60_i),
        .ulpi_rst_i   (ulpi_rst_i),
        .enable_i     (enable_i),
        .utmi         (utmi.master),
        .attached_o   (attached_o),
        .bus_reset_o  (bus_reset_o),
        .suspend_o    (suspend_o),
        .resume_o     (resume_o),
        .state_o      (state_o)
    );

    always #5 ulpi_clk60_i = ~ulpi_clk60_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge ulpi_clk60_i);
            #1;
        end
    endtask

    task automatic set_ls(input logic [1:0] ls, input logic rxa);
        utmi.utmi_linestate_i = ls;
        utmi.utmi_rxactive_i  = rxa;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(state_o), 32'd0);
        check_eq({tag, "_opmode"}, 32'(utmi.utmi_op_mode_o), 32'd1);
        check_eq({tag, "_xcvr"}, 32'(utmi.utmi_xcvrselect_o), 32'd1);
        check_eq({tag, "_term"}, 32'(utmi.utmi_termselect_o), 32'd0);
        check_eq({tag, "_pd"}, {30'd0, utmi.utmi_dppulldown_o, utmi.utmi_dmpulldown_o}, 32'd0);
        check_eq({tag, "_flags"}, {28'd0, attached_o, bus_reset_o, suspend_o, resume_o}, 32'd0);
    endtask

    initial begin
        ulpi_rst_i = 1'b1;
        enable_i   = 1'b0;
        utmi.utmi_txvalid_i = 1'b0;
        set_ls(2'b01, 1'b1);
        #22;
        check_reset_values("rst");
        ulpi_rst_i = 1'b0;
        tick(2);
        check_eq("detached_hold", 32'(state_o), 32'd0);

        // Attach: WAIT_ATTACH for exactly 10 cycles.
        enable_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("wait_state_%0d", i), 32'(state_o), 32'd1);
            check_eq($sformatf("wait_term_%0d", i), 32'(utmi.utmi_termselect_o), 32'd0);
        end
        tick();
        check_eq("att_state", 32'(state_o), 32'd2);
        check_eq("att_opmode", 32'(utmi.utmi_op_mode_o), 32'd0);
        check_eq("att_term", 32'(utmi.utmi_termselect_o), 32'd1);
        check_eq("att_attached", 32'(attached_o), 32'd1);
        tick(3);
        check_eq("att_stable", 32'(state_o), 32'd2);

        // Four SE0 cycles do not qualify.
        set_ls(2'b00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("se0_short_%0d", i), 32'(bus_reset_o), 32'd0);
        end
        set_ls(2'b01, 1'b1);
        tick();
        check_eq("se0_short_end", 32'(state_o), 32'd2);

        // Five SE0 cycles: bus reset visible after the 5th sample.
        set_ls(2'b00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("se0_pre_%0d", i), 32'(bus_reset_o), 32'd0);
        end
        tick();
        check_eq("busrst_rise", 32'(bus_reset_o), 32'd1);
        check_eq("busrst_state", 32'(state_o), 32'd3);
        check_eq("busrst_attached", 32'(attached_o), 32'd1);
        tick();
        check_eq("busrst_hold", 32'(bus_reset_o), 32'd1);
        set_ls(2'b01, 1'b1);
        tick();
        check_eq("busrst_fall", 32'(bus_reset_o), 32'd0);
        check_eq("busrst_exit_state", 32'(state_o), 32'd2);

        // Suspend after 20 idle-J cycles.
        set_ls(2'b01, 1'b0);
        tick(19);
        check_eq("susp_19", 32'(suspend_o), 32'd0);
        tick();
        check_eq("susp_20", 32'(suspend_o), 32'd1);
        check_eq("susp_state", 32'(state_o), 32'd4);
        check_eq("susp_term", 32'(utmi.utmi_termselect_o), 32'd1);

        // K resumes with a single-cycle pulse.
        set_ls(2'b10, 1'b0);
        tick();
        check_eq("res_suspend", 32'(suspend_o), 32'd0);
        check_eq("res_pulse", 32'(resume_o), 32'd1);
        check_eq("res_state", 32'(state_o), 32'd2);
        tick();
        check_eq("res_once", 32'(resume_o), 32'd0);
        set_ls(2'b01, 1'b1);
        tick();
        check_eq("res_low", 32'(resume_o), 32'd0);

        // Activity restarts the idle count.
        set_ls(2'b01, 1'b0);
        tick(19);
        check_eq("act_19a", 32'(suspend_o), 32'd0);
        set_ls(2'b01, 1'b1);
        tick();
        check_eq("act_pulse", 32'(suspend_o), 32'd0);
        set_ls(2'b01, 1'b0);
        tick(19);
        check_eq("act_19b", 32'(suspend_o), 32'd0);
        tick();
        check_eq("act_susp", 32'(suspend_o), 32'd1);

        // SE1 holds suspend; SE0 for 5 cycles goes to bus reset, no resume.
        set_ls(2'b11, 1'b0);
        tick();
        check_eq("se1_hold", 32'(state_o), 32'd4);
        set_ls(2'b00, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("ssp_se0_%0d", i), {29'd0, state_o}, 32'd4);
            check_eq($sformatf("ssp_nores_%0d", i), 32'(resume_o), 32'd0);
        end
        tick();
        check_eq("ssp_busrst", 32'(state_o), 32'd3);
        check_eq("ssp_nores", 32'(resume_o), 32'd0);
        set_ls(2'b01, 1'b1);
        tick();
        check_eq("ssp_exit", 32'(state_o), 32'd2);

        // Detach wins over the 5th SE0 sample.
        set_ls(2'b00, 1'b0);
        tick(4);
        check_eq("det_pre", 32'(state_o), 32'd2);
        enable_i = 1'b0;
        tick();
        check_eq("det_state", 32'(state_o), 32'd0);
        check_eq("det_opmode", 32'(utmi.utmi_op_mode_o), 32'd1);
        check_eq("det_busrst", 32'(bus_reset_o), 32'd0);
        check_eq("det_term", 32'(utmi.utmi_termselect_o), 32'd0);
        check_eq("det_attached", 32'(attached_o), 32'd0);

        // Async reset mid-WAIT_ATTACH.
        set_ls(2'b01, 1'b1);
        enable_i = 1'b1;
        tick(4);
        check_eq("wa_mid", 32'(state_o), 32'd1);
        #1 ulpi_rst_i = 1'b1;
        #1;
        check_reset_values("arst");
        #1 ulpi_rst_i = 1'b0;
        tick();
        check_eq("arst_rewait", 32'(state_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_fs_attach_ctrl.md
# usb_fs_attach_ctrl

Full-speed device attach and bus-state controller that drives the UTMI mode and pulldown inputs of the ULPI link wrapper and interprets its linestate/activity outputs. It sequences PHY configuration from detached to attached. It detects USB bus reset (SE0), suspend (idle J) and resume (K), and reports them to the device core as registered events. It sits between the device core and the wrapper, in the 60 MHz ULPI clock domain.

## Interface
- ATTACH_DELAY, 60000: cycles spent in WAIT_ATTACH before D+ pull-up is enabled (1 ms at 60 MHz); legal range 1..2^20-1.
- RESET_DETECT, 150: consecutive SE0 cycles that qualify as bus reset (2.5 us); legal range 1..2^20-1.
- SUSPEND_DETECT, 180000: consecutive idle-J cycles that qualify as suspend (3 ms); legal range 1..2^20-1.
- ulpi_clk60_i  in  1  60 MHz clock from PHY.
- ulpi_rst_i  in  1  Reset. Asynchronous, active-high.
- enable_i  in  1  Software attach request; 0 forces detach.
- utmi_linestate_i  in  2  Linestate from wrapper: 00 SE0, 01 J, 10 K, 11 SE1.
- utmi_rxactive_i  in  1  Receive activity from wrapper.
- utmi_txvalid_i  in  1  Transmit activity from device core.
- utmi_op_mode_o  out  2  To wrapper op_mode: 01 non-driving, 00 normal.
- utmi_xcvrselect_o  out  2  Constant 01 (FS).
- utmi_termselect_o  out  1  1 = FS termination/pull-up on.
- utmi_dppulldown_o  out  1  Constant 0 (device).
- utmi_dmpulldown_o  out  1  Constant 0 (device).
- attached_o  out  1  High in ATTACHED, BUS_RESET and SUSPENDED.
- bus_reset_o  out  1  High while in BUS_RESET.
- suspend_o  out  1  High while in SUSPENDED.
- resume_o  out  1  One-cycle pulse on resume.
- state_o  out  3  Current state encoding (debug).

## Operation
- States and encodings: DETACHED=0, WAIT_ATTACH=1, ATTACHED=2, BUS_RESET=3, SUSPENDED=4.
- Global priority: enable_i=0 forces DETACHED at the next edge from any state. This overrides every other transition in the same cycle, and all counters clear.
- DETACHED: op_mode=01, termselect=0. Goes to WAIT_ATTACH when enable_i=1.
- WAIT_ATTACH: outputs same as DETACHED. Wait counter increments each cycle; when it reaches ATTACH_DELAY-1, go to ATTACHED.
- ATTACHED: op_mode=00, termselect=1.
  - se0_cnt counts consecutive cycles with linestate=00 and clears on any other value. Linestate=00 with se0_cnt==RESET_DETECT-1 goes to BUS_RESET.
  - idle_cnt counts consecutive cycles with linestate=01 & !rxactive & !txvalid and clears otherwise. The qualifying condition with idle_cnt==SUSPEND_DETECT-1 goes to SUSPENDED.
  - The two conditions are mutually exclusive.
- BUS_RESET: op_mode=00, termselect=1. Stays while linestate=00. First cycle with linestate!=00 goes to ATTACHED with both counters cleared.
- SUSPENDED: op_mode=00, termselect=1.
  - linestate=10 (K) goes to ATTACHED; resume_o=1 for exactly the first ATTACHED cycle.
  - linestate=00 for RESET_DETECT consecutive cycles goes to BUS_RESET, with no resume_o.
  - J or SE1 holds SUSPENDED and clears se0_cnt.
- Counters are 20 bits and saturate; they never wrap. Counters clear on every state change.
- xcvrselect and pulldowns are constant registered values; they never change after reset.

## Timing
- All outputs are registered; state_o, attached_o, bus_reset_o and suspend_o are decoded from the state register.
- Reset values: state DETACHED, op_mode 01, xcvrselect 01, termselect 0, pulldowns 0, attached 0, bus_reset 0, suspend 0, resume 0, state_o 0.
- Latency, with N = threshold:
  - WAIT_ATTACH lasts exactly ATTACH_DELAY cycles.
  - BUS_RESET or SUSPENDED becomes visible in the cycle after the Nth consecutive qualifying sample.
  - Exit from BUS_RESET, and the K-to-resume transition, is visible one cycle after the sample.
- enable_i deassertion: outputs show DETACHED values one cycle later.
- Reset asserted mid-operation: all outputs return to reset values immediately, asynchronously.

## Test plan
Bench parameters: ATTACH_DELAY=10, RESET_DETECT=5, SUSPEND_DETECT=20.
- Attach: reset, then enable_i=1 at cycle 0. WAIT_ATTACH holds for 10 cycles; then op_mode=00, termselect=1, attached_o=1 and stay stable.
- Bus reset: hold SE0 for 4 cycles, then J. No BUS_RESET occurs. Then hold SE0 for 5 cycles: bus_reset_o rises on cycle 6 and falls one cycle after linestate=01.
- Suspend/resume: hold idle J for 20 cycles: suspend_o=1. Then drive K for one cycle: suspend_o=0, resume_o pulses once, state_o=2.
- Activity blocks suspend: idle J for 19 cycles, rxactive pulse for 1 cycle, then idle J for 19 more cycles. suspend_o stays 0; one further idle cycle sets it.
- Reset from suspend: in SUSPENDED, hold SE0 for 5 cycles. State goes to BUS_RESET with resume_o never asserted.
- Detach priority: drop enable_i in the same cycle as the 5th SE0 sample. Next cycle: state DETACHED, op_mode=01, bus_reset_o=0. Async ulpi_rst_i pulse mid-WAIT_ATTACH restores all reset values.
